// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the IF->ID fetch queue.
//   INSN_LEN / ADDR_LEN : instruction and PC widths used across the core
//   FQ_DEPTH            : default number of queue entries
//   fq_cnt_op_e         : occupancy update selector used by fetch_queue
package fetch_queue_pkg;

  localparam int INSN_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam int FQ_DEPTH = 4;

  typedef enum logic [1:0] {
    FQ_HOLD = 2'd0,
    FQ_INC  = 2'd1,
    FQ_DEC  = 2'd2
  } fq_cnt_op_e;

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage array for the fetch queue: DEPTH x WIDTH registers with one
// synchronous write port and one asynchronous (combinational) read port.
// Every entry is asynchronously cleared by reset_i.
//   clk_i    in  clock
//   reset_i  in  asynchronous active-high reset
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data at raddr_i (combinational)
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode. Buffers up to DEPTH
// {pc, inst} pairs and presents the oldest to decode over valid/ready.
// Back-pressures fetch when full; kill_i discards all entries in one cycle.
//   clk_i        in  clock
//   reset_i      in  asynchronous active-high reset
//   kill_i       in  synchronous flush (mispredict), beats push and pop
//   push_valid_i in  fetch presents an entry
//   push_pc_i    in  PC of the pushed entry
//   push_inst_i  in  instruction word of the pushed entry
//   push_ready_o out queue not full
//   stall_if_o   out queue full, stalls fetch
//   pop_valid_o  out queue not empty
//   pop_pc_o     out head PC (0 when empty)
//   pop_inst_o   out head instruction (0 when empty)
//   pop_ready_i  in  decode consumes the head
//   count_o      out occupancy 0..DEPTH
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int ADDR_W = ADDR_LEN,
  parameter int INSN_W = INSN_LEN
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       kill_i,
  input  logic                       push_valid_i,
  input  logic [ADDR_W-1:0]          push_pc_i,
  input  logic [INSN_W-1:0]          push_inst_i,
  output logic                       push_ready_o,
  output logic                       stall_if_o,
  output logic                       pop_valid_o,
  output logic [ADDR_W-1:0]          pop_pc_o,
  output logic [INSN_W-1:0]          pop_inst_o,
  input  logic                       pop_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INSN_W;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             push_fire, pop_fire;
  logic [ENT_W-1:0] head_entry;
  fq_cnt_op_e       cnt_op;

  // Full/empty come from registered count only, so pop_ready_i never
  // reaches push_ready_o combinationally.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign push_fire = push_valid_i & ~full;
  assign pop_fire  = pop_ready_i & ~empty;

  always_comb begin
    cnt_op = FQ_HOLD;
    if (push_fire && !pop_fire) begin
      cnt_op = FQ_INC;
    end else if (pop_fire && !push_fire) begin
      cnt_op = FQ_DEC;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (kill_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case (cnt_op)
        FQ_INC:  count <= count + CNT_W'(1);
        FQ_DEC:  count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A killed push must not land in storage either; the slot would be
  // harmless after the pointer reset, but keeping it out is cleaner.
  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (push_fire & ~kill_i),
    .waddr_i (wr_ptr),
    .wdata_i ({push_pc_i, push_inst_i}),
    .raddr_i (rd_ptr),
    .rdata_o (head_entry)
  );

  assign push_ready_o = ~full;
  assign stall_if_o   = full;
  assign pop_valid_o  = ~empty;
  assign pop_pc_o     = empty ? '0 : head_entry[ENT_W-1:INSN_W];
  assign pop_inst_o   = empty ? '0 : head_entry[INSN_W-1:0];
  assign count_o      = count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kill = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_inst = '0;
  logic        push_ready, stall_if, pop_valid;
  logic [31:0] pop_pc, pop_inst;
  logic        pop_ready = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INSN_W(32)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .kill_i       (kill),
    .push_valid_i (push_valid),
    .push_pc_i    (push_pc),
    .push_inst_i  (push_inst),
    .push_ready_o (push_ready),
    .stall_if_o   (stall_if),
    .pop_valid_o  (pop_valid),
    .pop_pc_o     (pop_pc),
    .pop_inst_o   (pop_inst),
    .pop_ready_i  (pop_ready),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, inst}, updated with the
  // handshake rules evaluated on the occupancy before the edge.
  logic [63:0] mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (kill) begin
      mq.delete();
    end else begin
      bit ps, pp;
      ps = push_valid && (mq.size() < DEPTH);
      pp = pop_ready && (mq.size() > 0);
      if (pp) void'(mq.pop_front());
      if (ps) mq.push_back({push_pc, push_inst});
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_pop_valid", 64'(pop_valid), 64'(mq.size() != 0));
      chk("m_push_ready", 64'(push_ready), 64'(mq.size() < DEPTH));
      chk("m_stall_if", 64'(stall_if), 64'(mq.size() == DEPTH));
      chk("m_head", {pop_pc, pop_inst}, (mq.size() != 0) ? mq[0] : 64'h0);
    end
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  // Drive inputs for one cycle, then return 1 time unit after the edge.
  task automatic cyc(input logic pv, input logic [31:0] pc, input logic pr, input logic k);
    push_valid = pv;
    push_pc    = pc;
    push_inst  = inst_of(pc);
    pop_ready  = pr;
    kill       = k;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    kill       = 1'b0;
  endtask

  task automatic push_spec(input logic [31:0] pc, input logic [31:0] inst);
    push_valid = 1'b1;
    push_pc    = pc;
    push_inst  = inst;
    pop_ready  = 1'b0;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
  endtask

  logic [31:0] exp_pc [4];

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_stall", 64'(stall_if), 64'd0);
    chk("rst_pop_pc", 64'(pop_pc), 64'd0);
    chk("rst_pop_inst", 64'(pop_inst), 64'd0);
    cmp_en = 1'b1;

    // 1: three pushes then in-order pops
    push_spec(32'h0, 32'h0000_0013);
    chk("t1_lat_valid", 64'(pop_valid), 64'd1);
    push_spec(32'h4, 32'h0010_0093);
    push_spec(32'h8, 32'h0020_0113);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_head_pc", 64'(pop_pc), 64'h0);
    chk("t1_head_inst", 64'(pop_inst), 64'h0000_0013);
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'h0};
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_pc", 64'(pop_pc), 64'(exp_pc[i]));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("t1_empty", 64'(pop_valid), 64'd0);
    chk("t1_empty_pc", 64'(pop_pc), 64'd0);

    // 2: fill, ignored 5th push, pop frees one slot
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(4 * i), 1'b0, 1'b0);
    chk("t2_push_ready", 64'(push_ready), 64'd0);
    chk("t2_stall", 64'(stall_if), 64'd1);
    chk("t2_count", 64'(count), 64'd4);
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    chk("t2_ignored_count", 64'(count), 64'd4);
    cyc(1'b1, 32'h10, 1'b1, 1'b0);
    chk("t2_after_pop_ready", 64'(push_ready), 64'd1);
    chk("t2_after_pop_count", 64'(count), 64'd3);
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    chk("t2_refill_count", 64'(count), 64'd4);
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_pc", 64'(pop_pc), 64'(exp_pc[i]));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("t2_drained", 64'(count), 64'd0);

    // 3: steady stream at occupancy 1
    cyc(1'b1, 32'h20, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_head_pc", 64'(pop_pc), 64'(32'h20 + 4 * i));
      cyc(1'b1, 32'(32'h24 + 4 * i), 1'b1, 1'b0);
      chk("t3_count", 64'(count), 64'd1);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // 4: wrap-around
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t4_head_pc", 64'(pop_pc), 64'(32'h10 + 4 * i));
      cyc(1'b1, 32'(32'h14 + 4 * i), 1'b1, 1'b0);
    end
    chk("t4_tail_pc", 64'(pop_pc), 64'h28);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // 5: kill beats a concurrent push
    cyc(1'b1, 32'h30, 1'b0, 1'b0);
    cyc(1'b1, 32'h34, 1'b0, 1'b0);
    cyc(1'b1, 32'h38, 1'b0, 1'b0);
    chk("t5_count_pre", 64'(count), 64'd3);
    cyc(1'b1, 32'h40, 1'b1, 1'b1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_pop_valid", 64'(pop_valid), 64'd0);
    chk("t5_push_ready", 64'(push_ready), 64'd1);
    cyc(1'b1, 32'h80, 1'b0, 1'b0);
    chk("t5_first_pc", 64'(pop_pc), 64'h80);
    chk("t5_first_inst", 64'(pop_inst), 64'(inst_of(32'h80)));
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_empty", 64'(pop_valid), 64'd0);

    // 6: asynchronous reset between edges
    cyc(1'b1, 32'h50, 1'b0, 1'b0);
    cyc(1'b1, 32'h54, 1'b0, 1'b0);
    chk("t6_count_pre", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pop_valid", 64'(pop_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_pop_pc", 64'(pop_pc), 64'd0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'h60, 1'b0, 1'b0);
    chk("t6_post_pc", 64'(pop_pc), 64'h60);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
